seven_seg_scan: RTL

Time-multiplexed four-digit seven-segment display driver. It sits directly downstream of the four-digit BCD up/down counter datapath and consumes its `digit3`..`digit0` outputs. It scans one digit per refresh period, decodes BCD to active-low segments, and applies optional leading-zero blanking and decimal points. Digits are snapshotted once per frame so a displayed frame never mixes old and new counter values.

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seven_seg_scan_if.sv | 33 +++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/seven_seg_scan.sv | 119 +++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Holds the active-low segment patterns for the decimal digits, the dash
// shown for invalid BCD, the all-off pattern, and the segment vector type.
// Segment order throughout is {g,f,e,d,c,b,a}, with 0 lighting a segment.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0    = 7'b1000000;
   localparam seg_t SEG_1    = 7'b1111001;
   localparam seg_t SEG_2    = 7'b0100100;
   localparam seg_t SEG_3    = 7'b0110000;
   localparam seg_t SEG_4    = 7'b0011001;
   localparam seg_t SEG_5    = 7'b0010010;
   localparam seg_t SEG_6    = 7'b0000010;
   localparam seg_t SEG_7    = 7'b1111000;
   localparam seg_t SEG_8    = 7'b0000000;
   localparam seg_t SEG_9    = 7'b0010000;
   localparam seg_t SEG_DASH = 7'b0111111;
   localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Signal bundle between the BCD counter datapath and the display driver.
//   digit3..digit0 : BCD digits, digit3 most significant (counter -> driver)
//   blank_en       : leading-zero blanking enable
//   dp_en          : per-digit decimal point enable, bit i = digit i
//   an             : active-low anode enables, bit i = digit i (driver -> pins)
//   seg            : active-low cathodes {g,f,e,d,c,b,a}
//   dp             : active-low decimal-point cathode
// master: the side that supplies digits and observes the display pins.
// slave : the display driver itself.
interface seven_seg_scan_if;
   import seven_seg_pkg::*;

   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;
   logic       blank_en;
   logic [3:0] dp_en;
   logic [3:0] an;
   seg_t       seg;
   logic       dp;

   modport master (
      output digit3, digit2, digit1, digit0, blank_en, dp_en,
      input  an, seg, dp
   );

   modport slave (
      input  digit3, digit2, digit1, digit0, blank_en, dp_en,
      output an, seg, dp
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
//   bcd : 4-bit input digit
//   seg : active-low segments {g,f,e,d,c,b,a}; codes 10-15 show a dash
module bcd_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed four-digit seven-segment display driver.
// Scans one digit per REFRESH_DIV clock cycles in order 0,1,2,3, decodes the
// BCD digit to active-low segments, applies optional leading-zero blanking
// and per-digit decimal points. The four digits are captured once per frame
// so a frame never mixes old and new counter values.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of seven_seg_scan_if (digits/enables in, an/seg/dp out)
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)
(
   input  logic            clk,
   input  logic            rst,
   seven_seg_scan_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       sel_reg;
   logic [1:0]       sel_next;
   logic [3:0]       snap_reg [4];
   logic [3:0]       live_digit [4];
   logic [3:0]       is_zero;
   logic [3:0]       blank_mask;
   logic             tick;
   logic             wrap;
   logic             slot_blank;
   logic [3:0]       digit_val;
   seg_t             dec_seg;
   logic [3:0]       an_reg;
   logic [3:0]       an_next;
   seg_t             seg_reg;
   seg_t             seg_next;
   logic             dp_reg;
   logic             dp_next;

   assign live_digit[0] = bus.digit0;
   assign live_digit[1] = bus.digit1;
   assign live_digit[2] = bus.digit2;
   assign live_digit[3] = bus.digit3;

   // A slot is a leading zero when it and every more significant digit of
   // the captured frame are zero. Digit 0 always shows, even when zero.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_zero
         assign is_zero[gi] = (snap_reg[gi] == 4'd0);
      end
      for (genvar gi = 1; gi < 4; gi++) begin : g_mask
         assign blank_mask[gi] = &is_zero[3:gi];
      end
   endgenerate
   assign blank_mask[0] = 1'b0;

   always_comb begin
      tick       = (cnt_reg == CNT_LAST);
      wrap       = (sel_reg == 2'd3);
      sel_next   = sel_reg + 2'd1;
      // On the wrap edge the snapshot is only being loaded, so slot 0 takes
      // its digit straight from the input to keep the new frame coherent.
      digit_val  = wrap ? bus.digit0 : snap_reg[sel_next];
      slot_blank = bus.blank_en & blank_mask[sel_next];
      an_next    = ~(4'b0001 << sel_next);
      seg_next   = dec_seg;
      dp_next    = ~bus.dp_en[sel_next];
      if (slot_blank) begin
         an_next  = 4'b1111;
         seg_next = SEG_OFF;
         dp_next  = 1'b1;
      end
   end

   bcd_to_7seg u_dec (
      .bcd (digit_val),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         sel_reg <= 2'd0;
      end else if (tick) begin
         cnt_reg <= '0;
         sel_reg <= sel_next;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) snap_reg[i] <= 4'd0;
      end else if (tick && wrap) begin
         for (int i = 0; i < 4; i++) snap_reg[i] <= live_digit[i];
      end
   end

   // Display pins only move on slot edges, so they never glitch mid-slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_reg  <= 4'b1110;
         seg_reg <= SEG_0;
         dp_reg  <= 1'b1;
      end else if (tick) begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
         dp_reg  <= dp_next;
      end
   end

   assign bus.an  = an_reg;
   assign bus.seg = seg_reg;
   assign bus.dp  = dp_reg;

endmodule
